// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants, FSM state type and the pattern decode
//               function for the 7-segment bus snooper. Segment vectors are
//               active-low with bit order {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  // Bit positions inside the {g,f,e,d,c,b,a} segment vector
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low glyphs for the 16 hex digits
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_HA = 7'b0001000;
  localparam logic [6:0] SEG_HB = 7'b0000011;
  localparam logic [6:0] SEG_HC = 7'b1000110;
  localparam logic [6:0] SEG_HD = 7'b0100001;
  localparam logic [6:0] SEG_HE = 7'b0000110;
  localparam logic [6:0] SEG_HF = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Dwell-tracking FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Decode result: known hex glyph, blank glyph, recovered nibble
  typedef struct packed {
    logic       known;
    logic       blank;
    logic [3:0] nibble;
  } dec_t;

  function automatic dec_t seg7_decode(input logic [6:0] pat);
    dec_t r;
    r = '{known: 1'b0, blank: 1'b0, nibble: 4'h0};
    case (pat)
      SEG_0:     begin r.known = 1'b1; r.nibble = 4'h0; end
      SEG_1:     begin r.known = 1'b1; r.nibble = 4'h1; end
      SEG_2:     begin r.known = 1'b1; r.nibble = 4'h2; end
      SEG_3:     begin r.known = 1'b1; r.nibble = 4'h3; end
      SEG_4:     begin r.known = 1'b1; r.nibble = 4'h4; end
      SEG_5:     begin r.known = 1'b1; r.nibble = 4'h5; end
      SEG_6:     begin r.known = 1'b1; r.nibble = 4'h6; end
      SEG_7:     begin r.known = 1'b1; r.nibble = 4'h7; end
      SEG_8:     begin r.known = 1'b1; r.nibble = 4'h8; end
      SEG_9:     begin r.known = 1'b1; r.nibble = 4'h9; end
      SEG_HA:    begin r.known = 1'b1; r.nibble = 4'hA; end
      SEG_HB:    begin r.known = 1'b1; r.nibble = 4'hB; end
      SEG_HC:    begin r.known = 1'b1; r.nibble = 4'hC; end
      SEG_HD:    begin r.known = 1'b1; r.nibble = 4'hD; end
      SEG_HE:    begin r.known = 1'b1; r.nibble = 4'hE; end
      SEG_HF:    begin r.known = 1'b1; r.nibble = 4'hF; end
      SEG_BLANK: r.blank = 1'b1;
      default:   r = '{known: 1'b0, blank: 1'b0, nibble: 4'h0};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_dec.sv
// ============================================================================
// Module      : seg7_pattern_dec
// Description : Combinational 7-segment pattern classifier. Reports whether
//               the active-low pattern is a hex glyph, the blank glyph, and
//               the recovered nibble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_known,
  output logic       o_blank,
  output logic [3:0] o_nibble
);

  dec_t w_dec;

  // Table lookup lives in the package so other checkers share one table
  always_comb begin
    w_dec = seg7_decode(i_pat);
  end

  assign o_known  = w_dec.known;
  assign o_blank  = w_dec.blank;
  assign o_nibble = w_dec.nibble;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Snoops a multiplexed active-low 7-segment bus, waits for a
//               stable dwell on one selected digit and records the decoded
//               nibble / DP per digit. Unknown glyphs raise a sticky error.
//               Optional staleness timeout per digit enabled by the macro
//               SEG7_SCAN_DECODER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [6:0]              iSEG,
  input  logic                    iSEG_DP,
  input  logic [NUM_DIGITS-1:0]   iDIG_SEL,
  output logic [4*NUM_DIGITS-1:0] oDIG,
  output logic [NUM_DIGITS-1:0]   oDP,
  output logic [NUM_DIGITS-1:0]   oVALID,
  output logic [NUM_DIGITS-1:0]   oBLANK,
  output logic                    oERR,
  output logic                    oUPD,
  output logic [2:0]              oUPD_IDX
);

  localparam int         c_SW     = NUM_DIGITS + 8;
  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

  logic [c_SW-1:0]       r_sync1, r_sync2, r_prev;
  state_t                r_state, w_state_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  w_commit;
  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_dp_n;
  logic [6:0]            w_seg;
  logic                  w_same;
  logic                  w_sel_ok;
  logic [2:0]            w_sel_idx;
  logic [3:0]            w_zeros;
  logic                  w_known, w_blank;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_to_hit;

  logic [4*NUM_DIGITS-1:0] r_dig;
  logic [NUM_DIGITS-1:0]   r_dp, r_valid, r_blank;
  logic                    r_err, r_upd;
  logic [2:0]              r_upd_idx;

  // Two-stage synchroniser plus a copy of the previous sample for change detect
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= {iDIG_SEL, iSEG_DP, iSEG};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_sel  = r_sync2[c_SW-1:8];
  assign w_dp_n = r_sync2[7];
  assign w_seg  = r_sync2[6:0];
  assign w_same = (r_sync2 == r_prev);

  // Exactly-one-low detection and index of the low select line
  always_comb begin
    w_zeros   = 4'd0;
    w_sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!w_sel[i]) begin
        w_zeros   = w_zeros + 4'd1;
        w_sel_idx = 3'(i);
      end
    end
    w_sel_ok = (w_zeros == 4'd1);
  end

  seg7_pattern_dec u_dec (
    .i_pat    (w_seg),
    .o_known  (w_known),
    .o_blank  (w_blank),
    .o_nibble (w_nibble)
  );

  // FSM state and dwell counter registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: the first sample of a new value counts as 1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 8'd0;
        if (w_sel_ok) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!w_sel_ok) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (!w_same) begin
          w_cnt_nxt = 8'd1;
        end else if ((r_cnt + 8'd1) == c_STABLE) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_STABLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!w_sel_ok) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (!w_same) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

`ifdef SEG7_SCAN_DECODER_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_timeout
    logic [c_TW-1:0] r_to_cnt;

    // Per-digit staleness counter, restarted by a commit to this digit
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        r_to_cnt <= '0;
      end else if (w_commit && (w_sel_idx == 3'(k))) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != c_TW'(TIMEOUT_CYCLES)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end

    // Fires on the edge where the counter reaches the limit
    assign w_to_hit[k] = (r_to_cnt == c_TW'(TIMEOUT_CYCLES - 1));
  end
`else
  assign w_to_hit = '0;
`endif

  // Per-digit result registers; only the selected digit changes on a commit
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_dig     <= '0;
      r_dp      <= '0;
      r_valid   <= '0;
      r_blank   <= '0;
      r_err     <= 1'b0;
      r_upd     <= 1'b0;
      r_upd_idx <= 3'd0;
    end else begin
      r_upd <= w_commit;
      if (w_commit) begin
        r_upd_idx <= w_sel_idx;
        if (!w_known && !w_blank) begin
          r_err <= 1'b1;
        end
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_to_hit[k]) begin
          r_valid[k] <= 1'b0;
          r_blank[k] <= 1'b0;
        end
        if (w_commit && (w_sel_idx == 3'(k))) begin
          r_dp[k]    <= ~w_dp_n;
          r_valid[k] <= w_known;
          r_blank[k] <= w_blank;
          if (w_known) begin
            r_dig[4*k +: 4] <= w_nibble;
          end
        end
      end
    end
  end

  assign oDIG     = r_dig;
  assign oDP      = r_dp;
  assign oVALID   = r_valid;
  assign oBLANK   = r_blank;
  assign oERR     = r_err;
  assign oUPD     = r_upd;
  assign oUPD_IDX = r_upd_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Scoreboard bench for seg7_scan_decoder. Stimulus pushes the
//               expected commit; a monitor pops on every oUPD pulse and also
//               checks that outputs stay put between commits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_decoder;

  localparam int NUM    = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  sel;
  logic [15:0] o_dig;
  logic [3:0]  o_dp, o_valid, o_blank;
  logic        o_err, o_upd;
  logic [2:0]  o_upd_idx;

  seg7_scan_decoder #(
    .NUM_DIGITS     (NUM),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (1000000)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iSEG     (seg),
    .iSEG_DP  (dp),
    .iDIG_SEL (sel),
    .oDIG     (o_dig),
    .oDP      (o_dp),
    .oVALID   (o_valid),
    .oBLANK   (o_blank),
    .oERR     (o_err),
    .oUPD     (o_upd),
    .oUPD_IDX (o_upd_idx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hex glyph table, index = nibble
  logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int          idx;
    logic [15:0] dig;
    logic [3:0]  valid, blank, dpv;
    logic        err;
    int unsigned t;
  } exp_t;

  exp_t q[$];

  // Model state after all issued stimulus; monitor state after all seen commits
  logic [15:0] m_dig, cur_dig;
  logic [3:0]  m_valid, m_blank, m_dp, cur_valid, cur_blank, cur_dp;
  logic        m_err, cur_err;
  logic [3:0]  last_sel;
  logic [6:0]  last_seg;
  logic        last_dp;

  int n_vec = 0, n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_dig = '0; m_valid = '0; m_blank = '0; m_dp = '0; m_err = 1'b0;
    cur_dig = '0; cur_valid = '0; cur_blank = '0; cur_dp = '0; cur_err = 1'b0;
    q.delete();
  endtask

  // Predict the commit of a value held long enough on the bus
  task automatic model_commit(input logic [3:0] s, input logic [6:0] g, input logic p);
    int   k, zeros, nib;
    exp_t e;
    zeros = 0; k = 0; nib = -1;
    for (int i = 0; i < NUM; i++) if (!s[i]) begin zeros++; k = i; end
    if (zeros != 1) return;
    for (int i = 0; i < 16; i++) if (pat[i] == g) nib = i;
    if (nib >= 0) begin
      m_dig[4*k +: 4] = 4'(nib);
      m_valid[k] = 1'b1; m_blank[k] = 1'b0;
    end else if (g == 7'h7F) begin
      m_valid[k] = 1'b0; m_blank[k] = 1'b1;
    end else begin
      m_valid[k] = 1'b0; m_blank[k] = 1'b0; m_err = 1'b1;
    end
    m_dp[k] = ~p;
    e.idx = k; e.dig = m_dig; e.valid = m_valid; e.blank = m_blank;
    e.dpv = m_dp; e.err = m_err; e.t = cyc;
    q.push_back(e);
  endtask

  // Drive one bus value for d cycles; a dwell of STABLE or more commits
  task automatic apply(input logic [3:0] s, input logic [6:0] g, input logic p, input int d);
    logic pp;
    pp = p;
    if (s == last_sel && g == last_seg && pp == last_dp) pp = ~pp;
    @(posedge clk);
    #1;
    sel = s; seg = g; dp = pp;
    last_sel = s; last_seg = g; last_dp = pp;
    n_vec++;
    if (d >= STABLE) model_commit(s, g, pp);
    repeat (d - 1) @(posedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (o_upd) begin
        if (q.size() == 0) begin
          check("unexpected_upd", {29'd0, o_upd_idx}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("upd_idx", {29'd0, o_upd_idx}, e.idx);
          check("latency", cyc - e.t, STABLE + 2);
          check("dig", {16'd0, o_dig}, {16'd0, e.dig});
          check("valid_blank_dp", {20'd0, o_valid, o_blank, o_dp},
                {20'd0, e.valid, e.blank, e.dpv});
          check("err", {31'd0, o_err}, {31'd0, e.err});
          cur_dig = e.dig; cur_valid = e.valid; cur_blank = e.blank;
          cur_dp = e.dpv; cur_err = e.err;
        end
      end else begin
        check("steady", {3'd0, o_err, o_dp, o_blank, o_valid, o_dig},
              {3'd0, cur_err, cur_dp, cur_blank, cur_valid, cur_dig});
      end
    end
  end

  task automatic check_zero(input string nm);
    check(nm, {3'd0, o_upd_idx, o_upd, o_err, o_dp, o_blank, o_valid, o_dig}, 32'd0);
  endtask

  initial begin
    int r;
    logic [3:0] s;
    logic [6:0] g;
    int d;
    clear_model();
    rst = 1'b1; sel = 4'hF; seg = 7'h7F; dp = 1'b1;
    last_sel = 4'hF; last_seg = 7'h7F; last_dp = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    @(negedge clk) rst = 1'b0;

    // Digit 0 shows "2", DP off
    apply(4'b1110, 7'b0100100, 1'b1, 10);

    // All 16 glyphs across digits 0..3
    for (int i = 0; i < 16; i++) apply(~(4'b0001 << (i % 4)), pat[i], 1'(i / 3), 20);

    // Glitching bus: no dwell long enough to commit
    for (int i = 0; i < 15; i++) apply(4'b1101, (i % 2) ? pat[1] : pat[8], 1'b0, 2);
    apply(4'b1101, pat[6], 1'b0, STABLE - 1);

    // Invalid selects never commit
    apply(4'b1100, pat[3], 1'b1, 20);
    apply(4'b1111, pat[3], 1'b1, 20);

    // Exact minimum dwell
    apply(4'b0111, pat[5], 1'b0, STABLE);
    apply(4'b1111, 7'h7F, 1'b1, 20);

    // Digit 2: blank then an unknown glyph
    apply(4'b1011, 7'h7F, 1'b1, 20);
    apply(4'b1011, 7'b0101010, 1'b0, 20);
    check("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset in the middle of a dwell
    apply(4'b1101, pat[7], 1'b0, 3);
    #3 rst = 1'b1;
    #1 check_zero("async_reset");
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_commit(last_sel, last_seg, last_dp);
    repeat (20) @(posedge clk);

    // Randomised traffic
    for (int v = 0; v < 300; v++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        s = ~(4'b0001 << $urandom_range(0, 3));
      end else begin
        s = 4'($urandom);
        while (s == 4'b1110 || s == 4'b1101 || s == 4'b1011 || s == 4'b0111) s = 4'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 6)      g = pat[$urandom_range(0, 15)];
      else if (r < 8) g = 7'h7F;
      else            g = 7'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3)       d = $urandom_range(1, STABLE - 1);
      else if (r == 3) d = STABLE;
      else             d = $urandom_range(STABLE + 1, 15);
      apply(s, g, 1'($urandom), d);
    end

    apply(4'b1111, 7'h7F, 1'b1, 30);
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
